data_bus_ctrl: RTL

- Data-side memory controller directly downstream of the CPU data port.
- Consumes the CPU's mem_req, mem_we, data_address and write data, and returns read data.
- Serves a local data RAM below IO_BASE, and forwards IO_BASE..0xFF to an external MMIO bus via a req/ack handshake.
- Raises busy to stall the core (ANDed into core clk_en) during slow MMIO accesses.

---
 rtl/data_bus_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/data_bus_ctrl.sv
// -----------------------------------------------------------------------------
// data_bus_ctrl
//   Data-side memory controller that sits directly behind the CPU data port.
//   Addresses below IO_BASE are served by a local data RAM with one cycle of
//   read latency. Addresses from IO_BASE to 0xFF are forwarded to an external
//   MMIO bus through a req/ack handshake. While an MMIO access is in flight,
//   the controller raises busy so the core can stall (busy is ANDed into the
//   core clock enable).
//
//   Optional feature: when DATA_BUS_IO_TIMEOUT_EN is defined, an MMIO access
//   that sees no io_ack within IO_TIMEOUT enabled cycles is forced to
//   complete. Reads then return 8'hFF, and the sticky io_err flag is set.
//   In the default build there is no timeout counter, and io_err is tied to 0.
//
// Parameters
//   IO_BASE     first MMIO address; the RAM covers 0 .. IO_BASE-1
//   IO_TIMEOUT  timeout in enabled cycles, 1..255 (optional feature only)
//
// Ports
//   clk          in   system clock
//   async_rst_n  in   asynchronous active-low reset
//   clk_en       in   global clock enable; nothing updates while it is low
//   cpu_req      in   data access request
//   cpu_we       in   1 = write, 0 = read
//   cpu_addr     in   byte address [7:0]
//   cpu_wdata    in   write data [7:0]
//   cpu_rdata    out  registered read data [7:0]
//   busy         out  stall request to the core
//   io_req       out  MMIO request, held until acknowledged
//   io_we        out  latched MMIO write strobe
//   io_addr      out  latched MMIO register index (cpu_addr[3:0])
//   io_wdata     out  latched MMIO write data [7:0]
//   io_rdata     in   MMIO read data, valid together with io_ack
//   io_ack       in   MMIO completion; held by the device until io_req drops
//   io_err       out  sticky timeout flag
// -----------------------------------------------------------------------------
module data_bus_ctrl #(
    parameter logic [7:0] IO_BASE    = 8'hF0,
    parameter int unsigned IO_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       async_rst_n,
    input  logic       clk_en,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       busy,
    output logic       io_req,
    output logic       io_we,
    output logic [3:0] io_addr,
    output logic [7:0] io_wdata,
    input  logic [7:0] io_rdata,
    input  logic       io_ack,
    output logic       io_err
);

    localparam int RAM_DEPTH = int'(IO_BASE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IO_WAIT = 2'd1,
        ST_IO_DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] rdata_q, rdata_d;
    logic       io_req_q, io_req_d;
    logic       io_we_q, io_we_d;
    logic [3:0] io_addr_q, io_addr_d;
    logic [7:0] io_wdata_q, io_wdata_d;

    logic       is_io_s;
    logic       ram_hit_s;
    logic       ram_we_s;
    logic [7:0] ram_rdata_s;
    logic       timeout_s;

    // The RAM contents are intentionally not reset.
    logic [7:0] mem_q [0:RAM_DEPTH-1];

`ifdef DATA_BUS_IO_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(IO_TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    assign is_io_s     = (cpu_addr >= IO_BASE);
    assign ram_hit_s   = (state_q == ST_IDLE) && cpu_req && !is_io_s;
    assign ram_we_s    = ram_hit_s && cpu_we;
    assign ram_rdata_s = mem_q[cpu_addr];

`ifdef DATA_BUS_IO_TIMEOUT_EN
    // A timeout fires on the last waiting cycle, which is the edge where the
    // counter would reach IO_TIMEOUT. A simultaneous ack takes priority.
    assign timeout_s = (state_q == ST_IO_WAIT) && !io_ack && (cnt_q == TIMEOUT_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic for the FSM and all registered outputs.
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        io_req_d   = io_req_q;
        io_we_d    = io_we_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
`ifdef DATA_BUS_IO_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (is_io_s) begin
                        // Capture the access so the MMIO bus sees stable
                        // signals while the core is stalled.
                        io_we_d    = cpu_we;
                        io_addr_d  = cpu_addr[3:0];
                        io_wdata_d = cpu_wdata;
                        io_req_d   = 1'b1;
                        state_d    = ST_IO_WAIT;
`ifdef DATA_BUS_IO_TIMEOUT_EN
                        cnt_d      = 8'd0;
`endif
                    end else begin
                        if (!cpu_we) begin
                            rdata_d = ram_rdata_s;
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IO_WAIT: begin
                if (io_ack) begin
                    if (!io_we_q) begin
                        rdata_d = io_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    io_req_d = 1'b0;
                    state_d  = ST_IO_DONE;
                end else if (timeout_s) begin
                    if (!io_we_q) begin
                        rdata_d = 8'hFF;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    io_req_d = 1'b0;
                    state_d  = ST_IO_DONE;
`ifdef DATA_BUS_IO_TIMEOUT_EN
                    err_d    = 1'b1;
`endif
                end else begin
`ifdef DATA_BUS_IO_TIMEOUT_EN
                    cnt_d   = cnt_q + 8'd1;
`endif
                    state_d = ST_IO_WAIT;
                end
            end
            ST_IO_DONE: begin
                // busy is low here so the core retires the access. The
                // request the core still presents is deliberately ignored.
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                io_req_d = 1'b0;
            end
        endcase
    end

    // Stall the core for an MMIO access that is starting or in progress.
    // Reset forces busy low immediately, even if an MMIO request is presented.
    always_comb begin
        busy = 1'b0;
        if (!async_rst_n) begin
            busy = 1'b0;
        end else if (state_q == ST_IO_WAIT) begin
            busy = 1'b1;
        end else if ((state_q == ST_IDLE) && cpu_req && is_io_s) begin
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
    end

    // State and output registers, updated only on enabled cycles.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q    <= ST_IDLE;
            rdata_q    <= 8'h00;
            io_req_q   <= 1'b0;
            io_we_q    <= 1'b0;
            io_addr_q  <= 4'h0;
            io_wdata_q <= 8'h00;
        end else if (clk_en) begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            io_req_q   <= io_req_d;
            io_we_q    <= io_we_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
        end
    end

`ifdef DATA_BUS_IO_TIMEOUT_EN
    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else if (clk_en) begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign io_err = err_q;
`else
    assign io_err = 1'b0;
`endif

    // Local data RAM write port; writes commit at the edge of the request cycle.
    always_ff @(posedge clk) begin
        if (clk_en && ram_we_s) begin
            mem_q[cpu_addr] <= cpu_wdata;
        end
    end

    assign cpu_rdata = rdata_q;
    assign io_req    = io_req_q;
    assign io_we     = io_we_q;
    assign io_addr   = io_addr_q;
    assign io_wdata  = io_wdata_q;

endmodule
